// File: rtl/xor_write_pipe_fwd_pkg.sv
// Shared constants and elaboration helpers for the XOR write-side pipeline.
package xor_write_pipe_fwd_pkg;

  localparam logic [1:0] OPT_READ  = 2'b00;
  localparam logic [1:0] OPT_WRITE = 2'b01;
  localparam logic [1:0] OPT_DEL   = 2'b11;
  localparam logic [1:0] OPT_RSVD  = 2'b10;

  // Position of the live/deleted flag, directly above the value field.
  function automatic int unsigned valid_bit_pos(int unsigned key_width,
                                                int unsigned value_width);
    return key_width + value_width;
  endfunction

  // Legal pipeline depths.
  function automatic bit pipe_depth_ok(int unsigned depth);
    return (depth >= 1) && (depth <= 16);
  endfunction

endpackage

// File: rtl/xor_all_URAM.sv
// XOR of one bank's own word with the words of all other write ports.
module xor_all_URAM #(
  parameter int unsigned NUM_WR     = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]            own_word,
  input  logic [(NUM_WR-1)*DATA_WIDTH-1:0] other_words,
  output logic [DATA_WIDTH-1:0]            xor_word
);

  // Fold every other-port word into the own word.
  always_comb begin
    xor_word = own_word;
    for (int unsigned j = 0; j < NUM_WR - 1; j++) begin
      xor_word = xor_word ^ other_words[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/xor_write_pipe_fwd.sv
// Write-side pipeline: delays write/delete entries to line up with table read
// data, XOR-encodes them per bank, forwards in-flight words to reads.
module xor_write_pipe_fwd
  import xor_write_pipe_fwd_pkg::*;
#(
  parameter int unsigned NUM_MUL     = 4,
  parameter int unsigned NUM_WR      = 8,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned VALUE_WIDTH = 31,
  parameter int unsigned KEY_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned PIPE_DEPTH  = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   en_in,
  input  logic [1:0]                             opt_in,
  input  logic [INDEX_WIDTH-1:0]                 index_in,
  input  logic [KEY_WIDTH-1:0]                   key_in,
  input  logic [VALUE_WIDTH-1:0]                 value_in,
  input  logic [NUM_MUL*(NUM_WR-1)*DATA_WIDTH-1:0] rd_BRAM_out_other,
  output logic [NUM_MUL*DATA_WIDTH-1:0]          write_out_xor,
  output logic [INDEX_WIDTH-1:0]                 write_out_index,
  output logic                                   write_out_valid,
  output logic                                   fwd_hit,
  output logic [DATA_WIDTH-1:0]                  fwd_data,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]        inflight_cnt,
  output logic                                   idle,
  output logic                                   opt_err
);

  localparam int unsigned VBIT    = valid_bit_pos(KEY_WIDTH, VALUE_WIDTH);
  localparam int unsigned CNT_W   = $clog2(PIPE_DEPTH + 1);
  localparam int unsigned OTHER_W = (NUM_WR - 1) * DATA_WIDTH;
  localparam int unsigned LAST    = PIPE_DEPTH - 1;

  if (!pipe_depth_ok(PIPE_DEPTH)) begin : g_bad_depth
    $error("PIPE_DEPTH must be within 1..16");
  end
  if (DATA_WIDTH < VBIT + 1) begin : g_bad_width
    $error("DATA_WIDTH too small for key, value and valid bit");
  end

  logic                  accept;
  logic                  is_read;
  logic                  is_rsvd;
  logic [DATA_WIDTH-1:0] new_word;

  // Flattened view of the stage registers; s0 is the youngest.
  logic [PIPE_DEPTH-1:0]             stage_valid;
  logic [PIPE_DEPTH*DATA_WIDTH-1:0]  stage_data;
  logic [PIPE_DEPTH*INDEX_WIDTH-1:0] stage_index;

  logic                  match_hit;
  logic [DATA_WIDTH-1:0] match_data;

  logic                  fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  opt_err_q;

  assign accept  = en_in && ((opt_in == OPT_WRITE) || (opt_in == OPT_DEL));
  assign is_read = en_in && (opt_in == OPT_READ);
  assign is_rsvd = en_in && (opt_in == OPT_RSVD);

  // Pack the incoming op into the stored word; the flag is 1 for write, 0 for delete.
  always_comb begin
    new_word = '0;
    new_word[KEY_WIDTH-1:0] = key_in;
    new_word[KEY_WIDTH +: VALUE_WIDTH] = value_in;
    new_word[VBIT] = ~opt_in[1];
  end

  for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;

    if (s == 0) begin : g_head
      // Non-accepted slots carry zeros so bubbles never leak stale words.
      assign valid_d = accept;
      assign data_d  = accept ? new_word : '0;
      assign index_d = accept ? index_in : '0;
    end else begin : g_tail
      assign valid_d = stage_valid[s-1];
      assign data_d  = stage_data[(s-1)*DATA_WIDTH +: DATA_WIDTH];
      assign index_d = stage_index[(s-1)*INDEX_WIDTH +: INDEX_WIDTH];
    end

    // Stage register: shifts every cycle, no stall.
    always_ff @(posedge clk) begin
      if (!reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        index_q <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        index_q <= index_d;
      end
    end

    assign stage_valid[s]                             = valid_q;
    assign stage_data[s*DATA_WIDTH +: DATA_WIDTH]     = data_q;
    assign stage_index[s*INDEX_WIDTH +: INDEX_WIDTH]  = index_q;
  end

  // Youngest-match priority: scan oldest to youngest so the youngest overwrites.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    for (int s = int'(PIPE_DEPTH) - 1; s >= 0; s--) begin
      if (stage_valid[s] && (stage_index[s*INDEX_WIDTH +: INDEX_WIDTH] == index_in)) begin
        match_hit  = 1'b1;
        match_data = stage_data[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(stage_valid[LAST]);

  // Forward result, occupancy counter and sticky reserved-opcode flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      cnt_q      <= '0;
      opt_err_q  <= 1'b0;
    end else begin
      fwd_hit_q  <= is_read && match_hit;
      fwd_data_q <= (is_read && match_hit) ? match_data : '0;
      cnt_q      <= cnt_d;
      opt_err_q  <= opt_err_q | is_rsvd;
    end
  end

  assign fwd_hit         = fwd_hit_q;
  assign fwd_data        = fwd_data_q;
  assign inflight_cnt    = cnt_q;
  assign idle            = (cnt_q == '0);
  assign opt_err         = opt_err_q;
  assign write_out_valid = stage_valid[LAST];
  assign write_out_index = stage_index[LAST*INDEX_WIDTH +: INDEX_WIDTH];

  for (genvar b = 0; b < NUM_MUL; b++) begin : g_bank
    xor_all_URAM #(
      .NUM_WR     (NUM_WR),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_xor (
      .own_word    (stage_data[LAST*DATA_WIDTH +: DATA_WIDTH]),
      .other_words (rd_BRAM_out_other[b*OTHER_W +: OTHER_W]),
      .xor_word    (write_out_xor[b*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_xor_write_pipe_fwd.sv
// Randomized and directed bench for xor_write_pipe_fwd with a history-based model.
module tb_xor_write_pipe_fwd;

  localparam int NUM_MUL = 4;
  localparam int NUM_WR  = 8;
  localparam int IW      = 12;
  localparam int VW      = 31;
  localparam int KW      = 32;
  localparam int DW      = 64;
  localparam int D       = 5;
  localparam int CW      = $clog2(D + 1);
  localparam int OW      = NUM_MUL * (NUM_WR - 1) * DW;
  localparam int MAXC    = 4096;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   en_in;
  logic [1:0]             opt_in;
  logic [IW-1:0]          index_in;
  logic [KW-1:0]          key_in;
  logic [VW-1:0]          value_in;
  logic [OW-1:0]          oth;
  logic [NUM_MUL*DW-1:0]  write_out_xor;
  logic [IW-1:0]          write_out_index;
  logic                   write_out_valid;
  logic                   fwd_hit;
  logic [DW-1:0]          fwd_data;
  logic [CW-1:0]          inflight_cnt;
  logic                   idle;
  logic                   opt_err;

  always #5 clk = ~clk;

  xor_write_pipe_fwd #(
    .NUM_MUL     (NUM_MUL),
    .NUM_WR      (NUM_WR),
    .INDEX_WIDTH (IW),
    .VALUE_WIDTH (VW),
    .KEY_WIDTH   (KW),
    .DATA_WIDTH  (DW),
    .PIPE_DEPTH  (D)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .en_in             (en_in),
    .opt_in            (opt_in),
    .index_in          (index_in),
    .key_in            (key_in),
    .value_in          (value_in),
    .rd_BRAM_out_other (oth),
    .write_out_xor     (write_out_xor),
    .write_out_index   (write_out_index),
    .write_out_valid   (write_out_valid),
    .fwd_hit           (fwd_hit),
    .fwd_data          (fwd_data),
    .inflight_cnt      (inflight_cnt),
    .idle              (idle),
    .opt_err           (opt_err)
  );

  // Per-cycle history of what was applied; the model derives outputs from it.
  bit            h_rstn [MAXC];
  bit            h_acc  [MAXC];
  bit            h_read [MAXC];
  bit            h_rsvd [MAXC];
  logic [IW-1:0] h_idx  [MAXC];
  logic [DW-1:0] h_word [MAXC];

  int cyc = 0;
  bit chk_on = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit rstn, input bit en, input logic [1:0] opt, input int idx,
                       input logic [KW-1:0] key, input logic [VW-1:0] val);
    reset    = rstn;
    en_in    = en;
    opt_in   = opt;
    index_in = IW'(idx);
    key_in   = key;
    value_in = val;
    h_rstn[cyc] = rstn;
    h_acc[cyc]  = en && (opt == 2'b01 || opt == 2'b11);
    h_read[cyc] = en && (opt == 2'b00);
    h_rsvd[cyc] = en && (opt == 2'b10);
    h_idx[cyc]  = IW'(idx);
    h_word[cyc] = DW'(key) | (DW'(val) << KW) | (DW'(~opt[1]) << (KW + VW));
  endtask

  task automatic step(input bit rstn, input bit en, input logic [1:0] opt, input int idx,
                      input logic [KW-1:0] key, input logic [VW-1:0] val);
    @(posedge clk);
    #1;
    cyc++;
    drive(rstn, en, opt, idx, key, val);
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 2'b00, 0, '0, '0);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Model: an op applied in cycle c is live if no reset was applied in any cycle >= c
  // before now; it sits in the pipe during cycles c+1..c+D and emerges in cycle c+D.
  task automatic check_cycle();
    int lr, src, p, cnt;
    bit e_valid, e_hit, e_err;
    logic [DW-1:0] e_fwd, e_word, acc;
    logic [IW-1:0] e_idx;
    lr = -1;
    for (int c = cyc - 1; c >= 0; c--) begin
      if (!h_rstn[c]) begin
        lr = c;
        break;
      end
    end
    src     = cyc - D;
    e_valid = (src > lr) && h_acc[src < 0 ? 0 : src];
    cnt = 0;
    for (int c = cyc - D; c < cyc; c++) if (c > lr && c >= 0 && h_acc[c]) cnt++;
    e_err = 1'b0;
    for (int c = lr + 1; c < cyc; c++) if (h_rsvd[c]) e_err = 1'b1;
    e_hit = 1'b0;
    e_fwd = '0;
    p = cyc - 1;
    if (p > lr && h_read[p]) begin
      for (int c = p - 1; c >= p - D && c > lr; c--) begin
        if (h_acc[c] && h_idx[c] == h_idx[p]) begin
          e_hit = 1'b1;
          e_fwd = h_word[c];
          break;
        end
      end
    end
    chk("write_out_valid", 64'(write_out_valid), 64'(e_valid));
    chk("inflight_cnt", 64'(inflight_cnt), 64'(cnt));
    chk("idle", 64'(idle), 64'(cnt == 0));
    chk("opt_err", 64'(opt_err), 64'(e_err));
    chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
    chk("fwd_data", fwd_data, e_fwd);
    if (e_valid || lr == cyc - 1) begin
      e_word = e_valid ? h_word[src] : '0;
      e_idx  = e_valid ? h_idx[src] : '0;
      chk("write_out_index", 64'(write_out_index), 64'(e_idx));
      for (int b = 0; b < NUM_MUL; b++) begin
        acc = e_word;
        for (int j = 0; j < NUM_WR - 1; j++) acc = acc ^ oth[(b*(NUM_WR-1)+j)*DW +: DW];
        chk("write_out_xor", write_out_xor[b*DW +: DW], acc);
      end
    end
  endtask

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (chk_on) check_cycle();
  end

  int exp_cnt [13] = '{1, 2, 3, 4, 5, 5, 5, 5, 4, 3, 2, 1, 0};

  initial begin
    oth = '0;
    drive(1'b0, 1'b0, 2'b00, 0, '0, '0);
    step(1'b0, 1'b0, 2'b00, 0, '0, '0);
    chk_on = 1'b1;
    step(1'b0, 1'b0, 2'b00, 0, '0, '0);
    at_neg();
    chk("reset_idle", 64'(idle), 64'd1);
    chk("reset_xor0", write_out_xor[63:0], 64'd0);
    idle_step();

    // Single write emerges after D cycles with the literal word.
    step(1'b1, 1'b1, 2'b01, 'h3A, 'h11, 'h22);
    for (int k = 1; k <= 4; k++) begin
      idle_step();
      at_neg();
      chk("t1_quiet", 64'(write_out_valid), 64'd0);
    end
    idle_step();
    at_neg();
    chk("t1_valid", 64'(write_out_valid), 64'd1);
    chk("t1_index", 64'(write_out_index), 64'h3A);
    chk("t1_word", write_out_xor[63:0], 64'h8000_0022_0000_0011);
    idle_step();
    at_neg();
    chk("t1_after", 64'(write_out_valid), 64'd0);

    // Same write with bank 2 other words 1,2,4..0x40.
    step(1'b1, 1'b1, 2'b01, 'h3A, 'h11, 'h22);
    for (int k = 1; k <= 4; k++) idle_step();
    idle_step();
    for (int j = 0; j < NUM_WR - 1; j++) oth[(2*(NUM_WR-1)+j)*DW +: DW] = DW'(1) << j;
    at_neg();
    chk("t2_bank2", write_out_xor[2*DW +: DW], 64'h8000_0022_0000_006E);
    chk("t2_bank0", write_out_xor[63:0], 64'h8000_0022_0000_0011);
    idle_step();
    oth = '0;

    // Delete then read forwards the word with the flag clear.
    step(1'b1, 1'b1, 2'b11, 5, 'hAB, 'h3);
    idle_step();
    step(1'b1, 1'b1, 2'b00, 5, '0, '0);
    step(1'b1, 1'b1, 2'b00, 6, '0, '0);
    at_neg();
    chk("t3_hit", 64'(fwd_hit), 64'd1);
    chk("t3_data", fwd_data, 64'h0000_0003_0000_00AB);
    idle_step();
    at_neg();
    chk("t3_miss_hit", 64'(fwd_hit), 64'd0);
    chk("t3_miss_data", fwd_data, 64'd0);
    for (int k = 0; k < 6; k++) idle_step();

    // Two writes to one index: newest forwards, both emerge.
    step(1'b1, 1'b1, 2'b01, 7, 'h77, 'h1);
    step(1'b1, 1'b1, 2'b01, 7, 'h77, 'h2);
    step(1'b1, 1'b1, 2'b00, 7, '0, '0);
    idle_step();
    at_neg();
    chk("t4_fwd_new", fwd_data, 64'h8000_0002_0000_0077);
    idle_step();
    step(1'b1, 1'b1, 2'b00, 7, '0, '0);
    at_neg();
    chk("t4_out1", write_out_xor[62:32], 64'd1);
    idle_step();
    at_neg();
    chk("t4_out2", write_out_xor[62:32], 64'd2);
    chk("t4_fwd_late", fwd_data, 64'h8000_0002_0000_0077);
    for (int k = 0; k < 6; k++) idle_step();

    // Occupancy ramp, saturation and drain.
    for (int k = 0; k < 14; k++) begin
      if (k < 8) step(1'b1, 1'b1, 2'b01, 'h100 + k, 'h5, k);
      else idle_step();
      if (k >= 1) begin
        at_neg();
        chk("t5_cnt", 64'(inflight_cnt), 64'(exp_cnt[k-1]));
      end
    end
    chk("t5_idle", 64'(idle), 64'd1);
    for (int k = 0; k < 2; k++) idle_step();

    // Reserved opcode, then mid-stream reset.
    step(1'b1, 1'b1, 2'b10, 'h20, 'h9, 'h9);
    step(1'b1, 1'b1, 2'b01, 'h21, 'h1, 'h1);
    at_neg();
    chk("t6_err", 64'(opt_err), 64'd1);
    step(1'b1, 1'b1, 2'b01, 'h22, 'h2, 'h2);
    step(1'b1, 1'b1, 2'b01, 'h23, 'h3, 'h3);
    step(1'b0, 1'b1, 2'b01, 'h24, 'h4, 'h4);
    at_neg();
    chk("t6_cnt3", 64'(inflight_cnt), 64'd3);
    idle_step();
    at_neg();
    chk("t6_rst_cnt", 64'(inflight_cnt), 64'd0);
    chk("t6_rst_err", 64'(opt_err), 64'd0);
    chk("t6_rst_idx", 64'(write_out_index), 64'd0);
    for (int k = 0; k < 6; k++) begin
      idle_step();
      at_neg();
      chk("t6_no_out", 64'(write_out_valid), 64'd0);
    end
    step(1'b1, 1'b1, 2'b01, 'h25, 'h5, 'h5);
    for (int k = 0; k < D; k++) idle_step();
    at_neg();
    chk("t6_new_out", 64'(write_out_valid), 64'd1);

    // Randomized traffic over a small index range to provoke forwarding hits.
    for (int k = 0; k < 2000; k++) begin
      bit rstn, en;
      logic [1:0] opt;
      int r;
      rstn = ($urandom_range(0, 79) != 0);
      en   = ($urandom_range(0, 3) != 0);
      r    = $urandom_range(0, 39);
      if (r == 0) opt = 2'b10;
      else begin
        case ($urandom_range(0, 2))
          0:       opt = 2'b00;
          1:       opt = 2'b01;
          default: opt = 2'b11;
        endcase
      end
      step(rstn, en, opt, $urandom_range(0, 7), $urandom, VW'($urandom));
      for (int w = 0; w < OW / 32; w++) oth[w*32 +: 32] = $urandom;
    end
    oth = '0;
    for (int k = 0; k < 8; k++) idle_step();
    at_neg();
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
